// File: rtl/piano_pkg.sv
// Shared note codes, segment patterns and scan-stage bundle
// for the piano display path.
package piano_pkg;

  localparam logic [2:0] NOTE_NONE = 3'd0;
  localparam logic [2:0] NOTE_C    = 3'd1;
  localparam logic [2:0] NOTE_D    = 3'd2;
  localparam logic [2:0] NOTE_E    = 3'd3;
  localparam logic [2:0] NOTE_F    = 3'd4;
  localparam logic [2:0] NOTE_G    = 3'd5;
  localparam logic [2:0] NOTE_A    = 3'd6;
  localparam logic [2:0] NOTE_B    = 3'd7;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_G     = 8'hC2;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;

  localparam int DP_BIT = 7;

  typedef struct packed {
    logic [2:0] code;
    logic       dp_n;
    logic       blank;
    logic [1:0] digit;
  } scan_s0_t;

  function automatic logic [3:0] an_sel_n(
    input logic [1:0] digit
  );
    logic [3:0] oh;
    oh = 4'b0001 << digit;
    return ~oh;
  endfunction

endpackage

// File: rtl/note_seg_rom.sv
// Registered note-code to active-low 7-segment decoder,
// shared by all digits; dp_n lights the decimal point.
module note_seg_rom
  import piano_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] code,
  input  logic       dp_n,
  output logic [7:0] seg
);

  logic [7:0] raw;
  logic [7:0] seg_d;
  logic [7:0] seg_q;

  always_comb begin
    raw = SEG_BLANK;
    unique case (code)
      NOTE_NONE: raw = SEG_BLANK;
      NOTE_C:    raw = SEG_C;
      NOTE_D:    raw = SEG_D;
      NOTE_E:    raw = SEG_E;
      NOTE_F:    raw = SEG_F;
      NOTE_G:    raw = SEG_G;
      NOTE_A:    raw = SEG_A;
      NOTE_B:    raw = SEG_B;
    endcase
    seg_d = raw;
    seg_d[DP_BIT] = raw[DP_BIT] & dp_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_q <= SEG_BLANK;
    else        seg_q <= seg_d;
  end

  assign seg = seg_q;

endmodule

// File: rtl/note_scroll_scanner.sv
// 4-deep note history shown on a multiplexed 4-digit display;
// newest note on the rightmost digit, one shared decoder.
module note_scroll_scanner
  import piano_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] note,
  input  logic       clear,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       note_push
);

  localparam int PW = $clog2(REFRESH_DIV);

  logic [2:0]      prev_note_q, prev_note_d;
  logic [3:0][2:0] hist_q, hist_d;
  logic            push_q, push_d;
  logic [PW-1:0]   prescaler_q, prescaler_d;
  logic [1:0]      digit_q, digit_d;
  logic [3:0]      an_q, an_d;
  logic            det;
  logic            wrap;
  scan_s0_t        s0;

  always_comb begin
    prev_note_d = note;
    det = (note != NOTE_NONE) && (note != prev_note_q);
    hist_d = hist_q;
    push_d = 1'b0;
    // clear outranks a same-cycle push
    if (clear) begin
      hist_d = '0;
    end else if (det) begin
      hist_d = {hist_q[2:0], note};
      push_d = 1'b1;
    end
  end

  always_comb begin
    wrap = (prescaler_q == PW'(REFRESH_DIV - 1));
    prescaler_d = wrap ? '0 : prescaler_q + 1'b1;
    digit_d = wrap ? digit_q + 2'd1 : digit_q;
  end

  always_comb begin
    s0.code  = hist_q[digit_q];
    s0.blank = (prescaler_q < PW'(BLANK_CYCLES));
    s0.digit = digit_q;
    // DP marks the newest note while its key is still down
    s0.dp_n  = !((digit_q == 2'd0) &&
                 (note != NOTE_NONE) &&
                 (note == hist_q[0]));
    an_d = s0.blank ? 4'b1111 : an_sel_n(s0.digit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_note_q <= NOTE_NONE;
      hist_q      <= '0;
      push_q      <= 1'b0;
      prescaler_q <= '0;
      digit_q     <= 2'd0;
      an_q        <= 4'b1111;
    end else begin
      prev_note_q <= prev_note_d;
      hist_q      <= hist_d;
      push_q      <= push_d;
      prescaler_q <= prescaler_d;
      digit_q     <= digit_d;
      an_q        <= an_d;
    end
  end

  note_seg_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .code  (s0.code),
    .dp_n  (s0.dp_n),
    .seg   (seg)
  );

  assign an        = an_q;
  assign note_push = push_q;

endmodule

// File: doc/note_scroll_scanner.md
Name: note_scroll_scanner

Overview:
Time-multiplexed controller for a 4-digit common-anode 7-segment display in the electric piano. Captures note key events into a 4-deep history; the newest note is on the rightmost digit. Scans the digits round-robin, sharing one registered note-to-segment decoder across all four digits. Sits between the key-scan/note logic and the board's seg/an pins.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); must be >= 4.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- note  in  3  current key: 0 = none, 1..7 = C,D,E,F,G,A,B
- clear  in  1  synchronous history clear, one-cycle pulse
- seg  out  8  segments, active-low, bit order .PGFEDCBA (bit7 = DP)
- an  out  4  digit anodes, active-low; an[0] = rightmost
- note_push  out  1  one-cycle pulse when a note enters the history

Behaviour:
- Reset (async on rst_n low, all state): hist[0..3]=0, prev_note=0, prescaler=0, digit=0, an=4'b1111, seg=8'hFF, note_push=0.
- Event detect: prev_note <= note every cycle. A push occurs when note!=0 and note!=prev_note. Holding a key gives one push. Release then re-press of the same key gives a new push. A direct change A->B pushes B.
- Push: hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=hist[0], hist[0]<=note. note_push is registered and high in the cycle after detection, aligned with the updated hist.
- Clear: all hist entries go to 0 on the next edge. If clear and a push detect occur in the same cycle, clear wins, the push is discarded, and note_push stays 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. On the wrap, digit <= digit+1 mod 4 (0,1,2,3,0...).
- Scan pipeline:
  - Stage 0: sel_code = hist[digit]; blank_s0 = (prescaler < BLANK_CYCLES).
  - Stage 1 (registered): seg = decode(sel_code) with DP applied; an = blank_s0 ? 4'b1111 : ~(4'b0001 << digit_s0).
  - Segments and anodes are therefore both one cycle behind the prescaler/digit, and always change on the same edge.
- Decode table (active-low), fixed: 0 -> FF (blank), 1 C -> C6, 2 D -> A1, 3 E -> 86, 4 F -> 8E, 5 G -> C2, 6 A -> 88, 7 B -> 83.
- DP: seg[7] is forced to 0 only when the digit selected in stage 0 is 0, note!=0, and note==hist[0]. This marks the newest note as still held. The DP condition is registered with the stage-1 outputs.
- Blanked slot: an=1111. seg still carries the decoded value (don't-care electrically) and must not be X.
- Reset mid-scan: outputs go to reset values immediately. After release, scanning restarts at digit 0, prescaler 0, with the first BLANK_CYCLES blanked.
- Widths: prescaler is $clog2(REFRESH_DIV) bits and digit is 2 bits; the digit wraps naturally.

Decomposition:
- Shared package piano_pkg:
  - note code localparams NOTE_NONE=0 … NOTE_B=7
  - segment constants SEG_BLANK=8'hFF and SEG_C…SEG_B
  - DP bit index 7
- One sub-module, note_seg_rom: registered 3-bit to 8-bit decoder with a dp_n input. It is instantiated once as the shared decoder.
- Event detect, history shift, prescaler and anode generation stay in the top block.

Test Plan:
(bench params REFRESH_DIV=8, BLANK_CYCLES=1)
- Reset: hold rst_n=0 with note=3 -> an=1111, seg=FF, note_push=0. Release and hold note=0 for 40 cycles -> every non-blank slot shows seg=FF; an cycles 1110, 1101, 1011, 0111 with 1 blank cycle per slot.
- Single press: note 0->1 held for 20 cycles -> exactly one note_push. The digit-0 slot shows seg=46 (C with DP lit); after release it shows C6.
- Sequence: press/release 1, 2, 3, 4, 5 -> note_push x5. Digits 3..0 show D,E,F,G = A1, 86, 8E, C2; C has been shifted out.
- Direct change: note 6 -> 7 with no release -> two pushes; hist[0]=7, hist[1]=6; the digit-0 slot shows 03 while 7 is held.
- Clear collision: assert clear in the same cycle as a new press of 2 -> no note_push, all slots show FF. A later re-press of 2 pushes normally.
- Async reset mid-slot: drop rst_n at prescaler=5, digit=2 -> outputs reach reset values before the next clk edge. After release, the first active anode is 1110 at cycle 2.
